timer_prescaler: RTL and testbench

//  Programmable clock prescaler feeding the count-enable input of the 20-bit sync counter.

---
 rtl/timer_prescaler_if.sv | 35 +++
 rtl/timer_prescaler.sv | 131 +++++++++++++
 tb/tb_timer_prescaler.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/timer_prescaler_if.sv
// Control/status bundle between a timer controller and timer_prescaler.
// TIMER_PRESC_ONESHOT_EN adds the oneshot request line.
interface timer_prescaler_if #(
  parameter int unsigned DIV_W = 16
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             div_load;
  logic [DIV_W-1:0] div_val;
  logic             div_ack;
  logic             tick;
  logic             running;
`ifdef TIMER_PRESC_ONESHOT_EN
  logic             oneshot;

  modport master (
    output start, stop, pause, div_load, div_val, oneshot,
    input  div_ack, tick, running
  );
  modport slave (
    input  start, stop, pause, div_load, div_val, oneshot,
    output div_ack, tick, running
  );
`else
  modport master (
    output start, stop, pause, div_load, div_val,
    input  div_ack, tick, running
  );
  modport slave (
    input  start, stop, pause, div_load, div_val,
    output div_ack, tick, running
  );
`endif
endinterface

// File: rtl/timer_prescaler.sv
// Programmable prescaler producing a 1-cycle tick every (div_reg+1) clocks.
// TIMER_PRESC_ONESHOT_EN enables single-tick mode selected by bus.oneshot at start.
module timer_prescaler #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DIV_RST = 999
) (
  input logic              clk,
  input logic              clr,
  timer_prescaler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RST);

  state_t           state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic [DIV_W-1:0] div_reg, div_n;
  logic [DIV_W-1:0] pend_val, pval_n;
  logic             pend, pend_n;
  logic             tick_q, tick_n;
  logic             ack_q, ack_n;
  logic             run_q;
  logic             pend_any;
  logic [DIV_W-1:0] pend_v;
  logic [DIV_W-1:0] reload;
  logic             os_exit;

`ifdef TIMER_PRESC_ONESHOT_EN
  logic os_q, os_n;
  // Leave RUN on the cycle after the single tick has been presented.
  assign os_exit = os_q & tick_q;
`else
  assign os_exit = 1'b0;
`endif

  assign bus.tick    = tick_q;
  assign bus.div_ack = ack_q;
  assign bus.running = run_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      cnt      <= DIV_INIT;
      div_reg  <= DIV_INIT;
      pend_val <= '0;
      pend     <= 1'b0;
      tick_q   <= 1'b0;
      ack_q    <= 1'b0;
      run_q    <= 1'b0;
`ifdef TIMER_PRESC_ONESHOT_EN
      os_q     <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      div_reg  <= div_n;
      pend_val <= pval_n;
      pend     <= pend_n;
      tick_q   <= tick_n;
      ack_q    <= ack_n;
      run_q    <= (state_n != IDLE);
`ifdef TIMER_PRESC_ONESHOT_EN
      os_q     <= os_n;
`endif
    end
  end

  // A load arriving on the reload cycle itself takes effect immediately.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    div_n    = div_reg;
    pval_n   = pend_val;
    pend_n   = pend;
    tick_n   = 1'b0;
    ack_n    = 1'b0;
`ifdef TIMER_PRESC_ONESHOT_EN
    os_n     = os_q;
`endif
    pend_any = pend | bus.div_load;
    pend_v   = bus.div_load ? bus.div_val : pend_val;
    reload   = pend_any ? pend_v : div_reg;

    case (state)
      IDLE: begin
        if (bus.div_load) begin
          div_n = bus.div_val;
          cnt_n = bus.div_val;
          ack_n = 1'b1;
        end
        if (bus.start && !bus.stop) begin
          state_n = RUN;
          cnt_n   = bus.div_load ? bus.div_val : div_reg;
`ifdef TIMER_PRESC_ONESHOT_EN
          os_n    = bus.oneshot;
`endif
        end
      end
      RUN, HOLD: begin
        if (bus.stop || os_exit) begin
          state_n = IDLE;
          cnt_n   = reload;
          div_n   = reload;
          ack_n   = pend_any;
          pend_n  = 1'b0;
        end else begin
          if (bus.div_load) begin
            pend_n = 1'b1;
            pval_n = bus.div_val;
          end
          // HOLD with pause released behaves as a normal RUN step.
          if ((state == RUN) || !bus.pause) begin
            state_n = bus.pause ? HOLD : RUN;
            if (cnt == '0) begin
              tick_n = 1'b1;
              cnt_n  = reload;
              if (pend_any) begin
                div_n  = pend_v;
                ack_n  = 1'b1;
                pend_n = 1'b0;
              end
            end else if (!bus.pause) begin
              cnt_n = cnt - DIV_W'(1);
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_timer_prescaler.sv
// Scoreboard bench for timer_prescaler: stimulus queues expected tick/div_ack events,
// a negedge monitor pops and compares them whenever either output is high.
module tb_timer_prescaler;
  localparam int unsigned DIV_W = 16;

  typedef struct {
    int   cyc;
    logic tick;
    logic ack;
  } ev_t;

  logic clk = 1'b0;
  logic clr;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];

  timer_prescaler_if #(.DIV_W(DIV_W)) tb_if ();

  timer_prescaler #(.DIV_W(DIV_W), .DIV_RST(999)) dut (
    .clk(clk),
    .clr(clr),
    .bus(tb_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp_v);
    end
  endfunction

  function automatic void push(int c, logic t, logic a);
    ev_t e;
    e.cyc  = c;
    e.tick = t;
    e.ack  = a;
    exp_q.push_back(e);
  endfunction

  // Inputs set at negedge cyc==t are sampled by posedge t+1.
  task automatic at(int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
  endtask

  // Monitor: any tick/div_ack must match the oldest queued expectation.
  always @(negedge clk) begin
    if ((tb_if.tick === 1'b1) || (tb_if.div_ack === 1'b1)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", int'({tb_if.tick, tb_if.div_ack}), 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("event_flags", int'({tb_if.tick, tb_if.div_ack}), int'({e.tick, e.ack}));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    clr             = 1'b1;
    tb_if.start     = 1'b0;
    tb_if.stop      = 1'b0;
    tb_if.pause     = 1'b0;
    tb_if.div_load  = 1'b0;
    tb_if.div_val   = '0;
`ifdef TIMER_PRESC_ONESHOT_EN
    tb_if.oneshot   = 1'b0;
`endif

    // Reset state, then default divisor 999
    repeat (2) @(negedge clk);
    clr = 1'b0;
    chk("rst_tick", int'(tb_if.tick), 0);
    chk("rst_ack", int'(tb_if.div_ack), 0);
    chk("rst_running", int'(tb_if.running), 0);
    chk("rst_cnt", int'(dut.cnt), 999);
    chk("rst_div", int'(dut.div_reg), 999);
    b = cyc;
    tb_if.start = 1'b1;
    push(b + 1001, 1'b1, 1'b0);
    push(b + 2001, 1'b1, 1'b0);
    at(b + 1); tb_if.start = 1'b0;
    at(b + 500); chk("run_running", int'(tb_if.running), 1);
    at(b + 2006); tb_if.stop = 1'b1;
    at(b + 2007); tb_if.stop = 1'b0;
    chk("stop_running", int'(tb_if.running), 0);
    at(b + 2020); chk("q_empty_a", exp_q.size(), 0);

    // IDLE load of 3, period 4, then divisor 0 gives continuous tick
    do_clr();
    b = cyc;
    tb_if.div_load = 1'b1; tb_if.div_val = 16'd3;
    push(b + 1, 1'b0, 1'b1);
    at(b + 1); tb_if.div_load = 1'b0; tb_if.start = 1'b1;
    push(b + 6, 1'b1, 1'b0);
    push(b + 10, 1'b1, 1'b0);
    push(b + 14, 1'b1, 1'b0);
    at(b + 2); tb_if.start = 1'b0;
    at(b + 15); tb_if.div_load = 1'b1; tb_if.div_val = 16'd0;
    push(b + 18, 1'b1, 1'b1);
    for (int k = 19; k <= 23; k++) push(b + k, 1'b1, 1'b0);
    at(b + 16); tb_if.div_load = 1'b0;
    at(b + 23); tb_if.stop = 1'b1;
    at(b + 24); tb_if.stop = 1'b0;
    chk("div0_stop_running", int'(tb_if.running), 0);
    at(b + 30); chk("q_empty_b", exp_q.size(), 0);

    // Divisor 9 running, reload to 4 mid-period
    do_clr();
    b = cyc;
    tb_if.div_load = 1'b1; tb_if.div_val = 16'd9;
    push(b + 1, 1'b0, 1'b1);
    at(b + 1); tb_if.div_load = 1'b0; tb_if.start = 1'b1;
    push(b + 12, 1'b1, 1'b0);
    push(b + 22, 1'b1, 1'b1);
    push(b + 27, 1'b1, 1'b0);
    push(b + 32, 1'b1, 1'b0);
    at(b + 2); tb_if.start = 1'b0;
    at(b + 15); tb_if.div_load = 1'b1; tb_if.div_val = 16'd4;
    at(b + 16); tb_if.div_load = 1'b0;
    at(b + 33); tb_if.stop = 1'b1;
    at(b + 34); tb_if.stop = 1'b0;
    at(b + 45); chk("q_empty_c", exp_q.size(), 0);

    // Pause for 6 cycles at cnt=5, then stop+start together
    do_clr();
    b = cyc;
    tb_if.div_load = 1'b1; tb_if.div_val = 16'd9;
    push(b + 1, 1'b0, 1'b1);
    at(b + 1); tb_if.div_load = 1'b0; tb_if.start = 1'b1;
    push(b + 18, 1'b1, 1'b0);
    push(b + 28, 1'b1, 1'b0);
    at(b + 2); tb_if.start = 1'b0;
    at(b + 6); tb_if.pause = 1'b1;
    at(b + 9);
    chk("hold_running", int'(tb_if.running), 1);
    chk("hold_cnt", int'(dut.cnt), 5);
    at(b + 12); tb_if.pause = 1'b0;
    at(b + 30); tb_if.stop = 1'b1; tb_if.start = 1'b1;
    at(b + 31); tb_if.stop = 1'b0; tb_if.start = 1'b0;
    chk("stopstart_running", int'(tb_if.running), 0);
    at(b + 45); chk("q_empty_d", exp_q.size(), 0);

    // clr while a divisor update is pending
    do_clr();
    b = cyc;
    tb_if.div_load = 1'b1; tb_if.div_val = 16'd9;
    push(b + 1, 1'b0, 1'b1);
    at(b + 1); tb_if.div_load = 1'b0; tb_if.start = 1'b1;
    push(b + 12, 1'b1, 1'b0);
    at(b + 2); tb_if.start = 1'b0;
    at(b + 14); tb_if.div_load = 1'b1; tb_if.div_val = 16'd4;
    at(b + 15); tb_if.div_load = 1'b0;
    at(b + 16); clr = 1'b1;
    at(b + 17); clr = 1'b0;
    chk("clr_running", int'(tb_if.running), 0);
    chk("clr_div", int'(dut.div_reg), 999);
    chk("clr_pend", int'(dut.pend), 0);
    at(b + 40); chk("q_empty_e", exp_q.size(), 0);

`ifdef TIMER_PRESC_ONESHOT_EN
    // Oneshot with divisor 2: single tick, then back to IDLE
    do_clr();
    b = cyc;
    tb_if.div_load = 1'b1; tb_if.div_val = 16'd2;
    push(b + 1, 1'b0, 1'b1);
    at(b + 1); tb_if.div_load = 1'b0; tb_if.start = 1'b1; tb_if.oneshot = 1'b1;
    push(b + 5, 1'b1, 1'b0);
    at(b + 2); tb_if.start = 1'b0; tb_if.oneshot = 1'b0;
    at(b + 5); chk("os_running_tick", int'(tb_if.running), 1);
    at(b + 6); chk("os_running_after", int'(tb_if.running), 0);
    at(b + 20); chk("q_empty_f", exp_q.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
